// File: rtl/rumble_pkg.sv
// Shared types and helpers for the rumble sequencer: state encoding, counter
// widths, PWM duty threshold and saturating millisecond increment.
package rumble_pkg;

  localparam int MS_W        = 12;
  localparam int EVT_W       = 16;
  localparam int ONMS_W      = 24;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ON       = 2'd1,
    TEST     = 2'd2,
    COOLDOWN = 2'd3
  } rumble_state_t;

  // Number of the 16 PWM phases that drive the motor; strength 3 yields 16,
  // which exceeds every phase value and therefore means always on.
  function automatic logic [4:0] duty_threshold(input logic [1:0] strength);
    logic [2:0] steps;
    steps = {1'b0, strength} + 3'd1;
    return {steps, 2'b00};
  endfunction

  function automatic logic [MS_W-1:0] ms_sat_inc(input logic [MS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rumble_tick.sv
// Free-running divider: pulse is high for one clk_74a cycle every N cycles,
// first pulse N-1 cycles after reset release.
module rumble_tick #(
  parameter int N = 4
) (
  input  logic clk_74a,
  input  logic reset_n,
  output logic pulse
);

  localparam int              CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign pulse = (cnt_reg == LAST);

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (pulse) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/rumble_sequencer.sv
// Rumble arbitration and timing: core rumble vs. settings test burst, minimum
// and maximum on-time with cooldown, PWM duty. Statistics need RUMBLE_STATS_EN.
module rumble_sequencer
  import rumble_pkg::*;
#(
  parameter int PRESCALE    = 74250,
  parameter int PWM_DIV     = 290,
  parameter int MIN_ON_MS   = 20,
  parameter int MAX_ON_MS   = 2000,
  parameter int COOLDOWN_MS = 500,
  parameter int TEST_MS     = 250
) (
  input  logic              clk_74a,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        strength,
  input  logic              core_rumble,
  input  logic              test_req,
  output logic              active,
  output logic              busy,
  output logic [EVT_W-1:0]  stat_events,
  output logic [ONMS_W-1:0] stat_on_ms
);

  localparam logic [MS_W-1:0] MIN_ON_LIM   = MS_W'(MIN_ON_MS);
  localparam logic [MS_W-1:0] MAX_ON_LIM   = MS_W'(MAX_ON_MS);
  localparam logic [MS_W-1:0] COOLDOWN_LIM = MS_W'(COOLDOWN_MS);
  localparam logic [MS_W-1:0] TEST_LIM     = MS_W'(TEST_MS);

  rumble_state_t          state_reg, state_next;
  logic [MS_W-1:0]        ms_cnt_reg, ms_cnt_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [3:0]             phase_reg;
  logic                   active_reg, active_next;
  logic                   tick, pwm_step, cr, pwm_on, driving;

  rumble_tick #(.N(PRESCALE)) u_ms_tick (
    .clk_74a (clk_74a),
    .reset_n (reset_n),
    .pulse   (tick)
  );

  rumble_tick #(.N(PWM_DIV)) u_pwm_tick (
    .clk_74a (clk_74a),
    .reset_n (reset_n),
    .pulse   (pwm_step)
  );

  // core_rumble comes from another clock domain
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], core_rumble};
    end
  end

  assign cr = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      phase_reg <= '0;
    end else if (pwm_step) begin
      phase_reg <= phase_reg + 4'd1;
    end
  end

  assign pwm_on  = ({1'b0, phase_reg} < duty_threshold(strength));
  assign driving = (state_reg == ON) || (state_reg == TEST);

  always_comb begin
    state_next  = state_reg;
    ms_cnt_next = ms_cnt_reg;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cr) begin
            state_next  = ON;
            ms_cnt_next = '0;
          end else if (test_req) begin
            state_next  = TEST;
            ms_cnt_next = '0;
          end
        end
        ON: begin
          if (ms_cnt_reg >= MAX_ON_LIM) begin
            state_next  = COOLDOWN;
            ms_cnt_next = '0;
          end else if (!cr && (ms_cnt_reg >= MIN_ON_LIM)) begin
            state_next = IDLE;
          end else if (tick) begin
            ms_cnt_next = ms_sat_inc(ms_cnt_reg);
          end
        end
        TEST: begin
          if (ms_cnt_reg >= TEST_LIM) begin
            state_next = IDLE;
          end else if (tick) begin
            ms_cnt_next = ms_sat_inc(ms_cnt_reg);
          end
        end
        COOLDOWN: begin
          if (ms_cnt_reg >= COOLDOWN_LIM) begin
            state_next = IDLE;
          end else if (tick) begin
            ms_cnt_next = ms_sat_inc(ms_cnt_reg);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Gating with enable lets active drop on the same edge the state leaves ON.
  assign active_next = enable && driving && pwm_on;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      ms_cnt_reg <= '0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ms_cnt_reg <= ms_cnt_next;
      active_reg <= active_next;
    end
  end

  assign active = active_reg;
  assign busy   = (state_reg != IDLE);

`ifdef RUMBLE_STATS_EN
  logic [EVT_W-1:0]  events_reg;
  logic [ONMS_W-1:0] on_ms_reg;
  logic              start_evt, on_tick;

  assign start_evt = (state_reg == IDLE) && ((state_next == ON) || (state_next == TEST));
  assign on_tick   = tick && driving;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      events_reg <= '0;
      on_ms_reg  <= '0;
    end else begin
      if (start_evt && !(&events_reg)) begin
        events_reg <= events_reg + 1'b1;
      end
      if (on_tick && !(&on_ms_reg)) begin
        on_ms_reg <= on_ms_reg + 1'b1;
      end
    end
  end

  assign stat_events = events_reg;
  assign stat_on_ms  = on_ms_reg;
`else
  assign stat_events = '0;
  assign stat_on_ms  = '0;
`endif

endmodule

// File: tb/tb_rumble_sequencer.sv
// Directed bench for rumble_sequencer with shortened timing parameters.
// Expected statistics follow RUMBLE_STATS_EN.
module tb_rumble_sequencer;

  localparam int PRESCALE    = 4;
  localparam int PWM_DIV     = 1;
  localparam int MIN_ON_MS   = 5;
  localparam int MAX_ON_MS   = 20;
  localparam int COOLDOWN_MS = 8;
  localparam int TEST_MS     = 6;

`ifdef RUMBLE_STATS_EN
  localparam int EXP_EVENTS = 2;
  localparam int EXP_ON_MS  = 11;
`else
  localparam int EXP_EVENTS = 0;
  localparam int EXP_ON_MS  = 0;
`endif

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  strength = 2'd3;
  logic        core_rumble = 1'b0;
  logic        test_req = 1'b0;
  logic        active;
  logic        busy;
  logic [15:0] stat_events;
  logic [23:0] stat_on_ms;

  int checks = 0;
  int failures = 0;

  logic busy_h   [0:255];
  logic active_h [0:255];
  int   cap_n = 0;

  rumble_sequencer #(
    .PRESCALE    (PRESCALE),
    .PWM_DIV     (PWM_DIV),
    .MIN_ON_MS   (MIN_ON_MS),
    .MAX_ON_MS   (MAX_ON_MS),
    .COOLDOWN_MS (COOLDOWN_MS),
    .TEST_MS     (TEST_MS)
  ) dut (
    .clk_74a     (clk_74a),
    .reset_n     (reset_n),
    .enable      (enable),
    .strength    (strength),
    .core_rumble (core_rumble),
    .test_req    (test_req),
    .active      (active),
    .busy        (busy),
    .stat_events (stat_events),
    .stat_on_ms  (stat_on_ms)
  );

  always #5 clk_74a = ~clk_74a;

  task automatic step(input int n);
    repeat (n) @(negedge clk_74a);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
    $display("check %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? busy : active;
  endfunction

  function automatic logic hist(input int sel, input int i);
    return (sel == 0) ? busy_h[i] : active_h[i];
  endfunction

  // Returns -1 when the level never appears inside the captured window.
  function automatic int find_lvl(input int sel, input int start, input logic lvl);
    if (start < 0) return -1;
    for (int i = start; i < cap_n; i++) begin
      if (hist(sel, i) === lvl) return i;
    end
    return -1;
  endfunction

  function automatic int run_len(input int sel, input int start, input logic lvl);
    int n;
    n = 0;
    if (start < 0) return 0;
    for (int i = start; i < cap_n; i++) begin
      if (hist(sel, i) !== lvl) break;
      n++;
    end
    return n;
  endfunction

  // Samples busy/active at each negedge; optionally toggles core_rumble mid-window.
  task automatic capture(input int n, input int on_at, input int off_at);
    cap_n = n;
    for (int i = 0; i < n; i++) begin
      busy_h[i]   = busy;
      active_h[i] = active;
      if (i == on_at)  core_rumble = 1'b1;
      if (i == off_at) core_rumble = 1'b0;
      @(negedge clk_74a);
    end
  endtask

  task automatic wait_sig(input string tag, input int sel, input logic lvl, input int limit);
    int n;
    n = 0;
    while ((sig(sel) !== lvl) && (n < limit)) begin
      @(negedge clk_74a);
      n++;
    end
    chk(tag, int'(sig(sel)), int'(lvl));
  endtask

  initial begin
    int b0, a0, hi, lo, cnt;

    // Reset
    #1 reset_n = 1'b0;
    step(3);
    chk("reset_busy", int'(busy), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_events", int'(stat_events), 0);
    chk("reset_on_ms", int'(stat_on_ms), 0);
    reset_n = 1'b1;
    step(3);

    // Short pulse: 3 clocks of core_rumble, strength 3
    enable = 1'b1;
    strength = 2'd3;
    core_rumble = 1'b1;
    step(3);
    core_rumble = 1'b0;
    capture(40, -1, -1);
    b0 = find_lvl(0, 0, 1'b1);
    hi = run_len(0, b0, 1'b1);
    chk("short_busy_start", b0, 0);
    chk_rng("short_busy_len", hi, 18, 21);
    a0 = find_lvl(1, 0, 1'b1);
    chk("short_active_lag", a0, b0 + 1);
    chk("short_active_len", run_len(1, a0, 1'b1), hi);
    chk("short_idle_busy", int'(busy), 0);
    chk("short_idle_active", int'(active), 0);

    // Arbitration: test_req and synchronized core rise together -> ON, test dropped
    core_rumble = 1'b1;
    step(2);
    test_req = 1'b1;
    step(1);
    test_req = 1'b0;
    core_rumble = 1'b0;
    capture(60, -1, -1);
    b0 = find_lvl(0, 0, 1'b1);
    hi = run_len(0, b0, 1'b1);
    chk("arb_busy_start", b0, 0);
    chk_rng("arb_on_len", hi, 18, 21);
    chk("arb_no_queued_test", find_lvl(0, b0 + hi, 1'b1), -1);

    // Test burst alone
    test_req = 1'b1;
    step(1);
    test_req = 1'b0;
    capture(40, -1, -1);
    b0 = find_lvl(0, 0, 1'b1);
    hi = run_len(0, b0, 1'b1);
    chk("test_busy_start", b0, 0);
    chk_rng("test_len", hi, 22, 25);
    chk("test_active_len", run_len(1, b0 + 1, 1'b1), hi);
    chk("test_no_rebusy", find_lvl(0, b0 + hi, 1'b1), -1);

    // core_rumble rising mid-TEST is ignored until TEST ends, then ON follows
    test_req = 1'b1;
    step(1);
    test_req = 1'b0;
    capture(60, 8, -1);
    b0 = find_lvl(0, 0, 1'b1);
    hi = run_len(0, b0, 1'b1);
    lo = run_len(0, b0 + hi, 1'b0);
    chk_rng("midtest_test_len", hi, 22, 25);
    chk("midtest_idle_gap", lo, 1);
    chk("midtest_on_after", int'(hist(0, b0 + hi + lo)), 1);
    core_rumble = 1'b0;
    wait_sig("midtest_back_idle", 0, 1'b0, 60);
    step(4);

    // Abort: enable dropped during ON overrides the minimum on-time
    core_rumble = 1'b1;
    wait_sig("abort_enter_on", 0, 1'b1, 10);
    step(8);
    chk("abort_pre_active", int'(active), 1);
    enable = 1'b0;
    step(1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_active", int'(active), 0);
    step(5);
    chk("abort_stays_idle", int'(busy), 0);
    enable = 1'b1;
    step(2);
    chk("abort_reenter", int'(busy), 1);

    // Duty: phase advances every clock, so any 16 clocks cover one PWM period
    strength = 2'd0;
    step(3);
    for (int s = 0; s < 3; s++) begin
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (active === 1'b1) cnt++;
        step(1);
      end
      chk($sformatf("duty_s%0d", s), cnt, 4 * (s + 1));
      strength = 2'(s + 1);
      step(2);
    end
    core_rumble = 1'b0;
    strength = 2'd3;
    wait_sig("duty_back_idle", 0, 1'b0, 60);
    step(4);

    // Overrun: 20 ms on, 8 ms forced off, then ON again
    core_rumble = 1'b1;
    capture(150, -1, -1);
    a0 = find_lvl(1, 0, 1'b1);
    hi = run_len(1, a0, 1'b1);
    lo = run_len(1, a0 + hi, 1'b0);
    chk_rng("overrun_on_len", hi, 78, 81);
    chk_rng("overrun_cool_len", lo, 31, 34);
    chk("overrun_reenter", int'(hist(1, a0 + hi + lo)), 1);

    // Asynchronous reset in the middle of the next cooldown
    wait_sig("cool2_active_low", 1, 1'b0, 100);
    step(5);
    chk("cool2_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_active", int'(active), 0);
    chk("async_rst_events", int'(stat_events), 0);
    chk("async_rst_on_ms", int'(stat_on_ms), 0);
    core_rumble = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);

    // Statistics: one TEST burst plus one minimum-length ON
    test_req = 1'b1;
    step(1);
    test_req = 1'b0;
    wait_sig("stats_test_idle", 0, 1'b0, 60);
    step(2);
    core_rumble = 1'b1;
    step(3);
    core_rumble = 1'b0;
    wait_sig("stats_on_idle", 0, 1'b0, 60);
    step(2);
    chk("stats_events", int'(stat_events), EXP_EVENTS);
    chk("stats_on_ms", int'(stat_on_ms), EXP_ON_MS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
